// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes plus the state and grant
// encodings of the register bridge.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite channel bundle shared by the AXI4-Lite blocks; payloads are
// grouped into per-channel packed structs.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4
) ();

  typedef struct packed { logic [A-1:0] addr; } ax_t;
  typedef struct packed { logic [8*N-1:0] data; logic [N-1:0] strb; } w_t;
  typedef struct packed { logic [1:0] resp; } b_t;
  typedef struct packed { logic [8*N-1:0] data; logic [1:0] resp; } r_t;

  // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
  // valid, once raised, holds with a stable payload until that cycle.
  logic arvalid, arready;
  ax_t  ar;
  logic awvalid, awready;
  ax_t  aw;
  logic wvalid, wready;
  w_t   w;
  logic bvalid, bready;
  b_t   b;
  logic rvalid, rready;
  r_t   r;

  modport slave (
    input  arvalid, ar, awvalid, aw, wvalid, w, bready, rready,
    output arready, awready, wready, bvalid, b, rvalid, r
  );

endinterface

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave to single-outstanding req/ack register bus, with fair
// read/write arbitration and an acknowledge timeout.
module axi4_lite_reg_bridge
  import axi4_lite_pkg::*;
#(
  parameter int A       = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           aclk,
  input  logic           aresetn,
  axi4_if.slave          axi4_s,
  output logic           reg_req,
  output logic           reg_wr,
  output logic [A-1:0]   reg_addr,
  output logic [8*N-1:0] reg_wdata,
  output logic [N-1:0]   reg_wstrb,
  input  logic           reg_ack,
  input  logic [8*N-1:0] reg_rdata,
  input  logic           reg_err,
  output logic [1:0]     dbg_state
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [A-1:0]  ADDR_MASK = ~A'((1 << $clog2(N)) - 1);

  bridge_state_e   state_q, state_d;
  grant_e          last_grant;
  logic            aw_held, w_held;
  logic [A-1:0]    aw_addr_q;
  logic [8*N-1:0]  w_data_q;
  logic [N-1:0]    w_strb_q;
  logic [TW-1:0]   tmo_cnt;
  logic            bvalid_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [8*N-1:0]  rdata_q;
  logic            wr_pend, rd_pend, rd_grant, wr_grant, ack, tmo_exp, resp_done;

  // On a tie the request type that did not win last time is served.
  assign wr_pend   = aw_held & w_held;
  assign rd_pend   = axi4_s.arvalid;
  assign rd_grant  = (state_q == ST_IDLE) && rd_pend && (!wr_pend || last_grant == GRANT_WRITE);
  assign wr_grant  = (state_q == ST_IDLE) && wr_pend && (!rd_pend || last_grant == GRANT_READ);
  assign ack       = reg_req & reg_ack;
  assign tmo_exp   = (TIMEOUT != 0) && (state_q == ST_REQ) && !ack && (tmo_cnt == TMO_LAST);
  assign resp_done = (bvalid_q & axi4_s.bready) | (rvalid_q & axi4_s.rready);

  assign axi4_s.arready = rd_grant;
  assign axi4_s.awready = ~aw_held;
  assign axi4_s.wready  = ~w_held;
  assign axi4_s.bvalid  = bvalid_q;
  assign axi4_s.b       = bresp_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.r       = {rdata_q, rresp_q};
  assign dbg_state      = state_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_grant || wr_grant) state_d = ST_REQ;
      ST_REQ:  if (ack || tmo_exp)       state_d = ST_RESP;
      ST_RESP: if (resp_done)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // AW and W are buffered independently; both free up as soon as the write is granted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (wr_grant) begin
        aw_held <= 1'b0;
      end else if (axi4_s.awvalid && !aw_held) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi4_s.aw.addr;
      end
      if (wr_grant) begin
        w_held <= 1'b0;
      end else if (axi4_s.wvalid && !w_held) begin
        w_held   <= 1'b1;
        w_data_q <= axi4_s.w.data;
        w_strb_q <= axi4_s.w.strb;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_cnt <= '0;
    end else if (rd_grant || wr_grant) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_REQ && !ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reg_req    <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
      last_grant <= GRANT_WRITE;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else if (rd_grant) begin
      reg_req    <= 1'b1;
      reg_wr     <= 1'b0;
      reg_addr   <= axi4_s.ar.addr & ADDR_MASK;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
      last_grant <= GRANT_READ;
    end else if (wr_grant) begin
      reg_req    <= 1'b1;
      reg_wr     <= 1'b1;
      reg_addr   <= aw_addr_q & ADDR_MASK;
      reg_wdata  <= w_data_q;
      reg_wstrb  <= w_strb_q;
      last_grant <= GRANT_WRITE;
    end else if (state_q == ST_REQ && (ack || tmo_exp)) begin
      // An ack in the expiry cycle takes precedence over the timeout.
      reg_req <= 1'b0;
      if (reg_wr) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (ack && !reg_err) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        rvalid_q <= 1'b1;
        rresp_q  <= (ack && !reg_err) ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= ack ? reg_rdata : '0;
      end
    end else if (state_q == ST_RESP) begin
      if (bvalid_q && axi4_s.bready) bvalid_q <= 1'b0;
      if (rvalid_q && axi4_s.rready) rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Self-checking bench for axi4_lite_reg_bridge: directed scenarios plus a
// randomized mix, checked against a transaction-level model of the bridge.
module tb_axi4_lite_reg_bridge;

  localparam int TMO = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        reg_req, reg_wr;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack, reg_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  bit m_last_write;          // model: type of the most recent grant
  logic [31:0] exp_q[$];     // expected read data, in issue order

  axi4_if #(.A(32), .N(4)) axi ();

  axi4_lite_reg_bridge #(.A(32), .N(4), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi4_s(axi),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .reg_err(reg_err), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic apply_reset();
    aresetn = 1'b0;
    axi.arvalid = 0; axi.ar.addr = '0;
    axi.awvalid = 0; axi.aw.addr = '0;
    axi.wvalid = 0;  axi.w.data = '0; axi.w.strb = '0;
    axi.bready = 0;  axi.rready = 0;
    reg_ack = 0; reg_rdata = '0; reg_err = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    m_last_write = 1'b1;
  endtask

  task automatic ar_handshake(input logic [31:0] addr);
    int n = 0;
    axi.arvalid = 1; axi.ar.addr = addr;
    @(negedge aclk);
    while (!axi.arready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (axi.arready !== 1'b1) begin failures++; $display("FAIL ar_handshake arready=%b required=1", axi.arready); end
    tick();
    axi.arvalid = 0;
  endtask

  task automatic aw_handshake(input logic [31:0] addr);
    int n = 0;
    axi.awvalid = 1; axi.aw.addr = addr;
    @(negedge aclk);
    while (!axi.awready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (axi.awready !== 1'b1) begin failures++; $display("FAIL aw_handshake awready=%b required=1", axi.awready); end
    tick();
    axi.awvalid = 0;
  endtask

  task automatic w_handshake(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    axi.wvalid = 1; axi.w.data = data; axi.w.strb = strb;
    @(negedge aclk);
    while (!axi.wready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (axi.wready !== 1'b1) begin failures++; $display("FAIL w_handshake wready=%b required=1", axi.wready); end
    tick();
    axi.wvalid = 0;
  endtask

  // Acts as the register slave for one access and as the AXI master for its response.
  task automatic serve(input bit exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_strb, input bit ack_en, input int delay,
                       input logic [31:0] rd, input bit err, input int rdy_delay);
    int n = 0;
    int cnt;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data, got_data;
    logic        got_valid;
    logic [1:0]  got_resp;
    while (!reg_req && n < 50) begin tick(); n++; end
    checks++;
    if (reg_req !== 1'b1) begin
      failures++; $display("FAIL req_wait reg_req=%b required=1", reg_req);
    end else begin
      m_last_write = exp_wr;
      if (!exp_wr) axi.arvalid = 0;
      checks++;
      if ({reg_wr, reg_addr, reg_wdata, reg_wstrb} !== {exp_wr, exp_addr, exp_wdata, exp_strb}) begin
        failures++;
        $display("FAIL req_fields wr=%b addr=%h wdata=%h strb=%b required wr=%b addr=%h wdata=%h strb=%b",
                 reg_wr, reg_addr, reg_wdata, reg_wstrb, exp_wr, exp_addr, exp_wdata, exp_strb);
      end
      exp_resp = (ack_en && !err) ? OKAY : SLVERR;
      exp_data = ack_en ? rd : 32'h0;
      if (!exp_wr) exp_q.push_back(exp_data);
      if (ack_en) begin
        for (int i = 1; i < delay; i++) begin
          tick();
          checks++;
          if ({reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, exp_wr, exp_addr, exp_wdata, exp_strb}) begin
            failures++;
            $display("FAIL req_stable req=%b addr=%h wdata=%h required req=1 addr=%h wdata=%h",
                     reg_req, reg_addr, reg_wdata, exp_addr, exp_wdata);
          end
        end
        reg_ack = 1; reg_rdata = rd; reg_err = err;
        tick();
        reg_ack = 0; reg_err = 0; reg_rdata = $urandom;
      end else begin
        cnt = 1;
        while (reg_req && cnt < 100) begin tick(); if (reg_req) cnt++; end
        checks++;
        if (cnt !== TMO) begin failures++; $display("FAIL timeout_len req_cycles=%0d required=%0d", cnt, TMO); end
        if (rdy_delay < 1) rdy_delay = 1;
      end
      for (int i = 0; i <= rdy_delay; i++) begin
        got_valid = exp_wr ? axi.bvalid : axi.rvalid;
        got_resp  = exp_wr ? axi.b.resp : axi.r.resp;
        got_data  = exp_wr ? 32'h0 : axi.r.data;
        checks++;
        if ({got_valid, got_resp, got_data, reg_req} !== {1'b1, exp_resp, (exp_wr ? 32'h0 : exp_q[0]), 1'b0}) begin
          failures++;
          $display("FAIL resp wr=%b valid=%b resp=%b data=%h req=%b required valid=1 resp=%b data=%h req=0",
                   exp_wr, got_valid, got_resp, got_data, reg_req, exp_resp, (exp_wr ? 32'h0 : exp_q[0]));
        end
        if (i < rdy_delay) begin
          if (!ack_en && i == 0) begin reg_ack = 1; reg_rdata = 32'hBAD0_BAD0; end
          tick();
          reg_ack = 0;
        end
      end
      if (exp_wr) axi.bready = 1; else axi.rready = 1;
      tick();
      axi.bready = 0; axi.rready = 0;
      got_valid = exp_wr ? axi.bvalid : axi.rvalid;
      checks++;
      if (got_valid !== 1'b0) begin failures++; $display("FAIL resp_clear valid=%b required=0", got_valid); end
      if (!exp_wr) void'(exp_q.pop_front());
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input bit ack_en, input int delay,
                         input logic [31:0] rd, input bit err, input int rdy);
    ar_handshake(addr);
    checks++;
    if (reg_req !== 1'b1) begin failures++; $display("FAIL read_latency reg_req=%b required=1", reg_req); end
    serve(1'b0, word(addr), 32'h0, 4'h0, ack_en, delay, rd, err, rdy);
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit w_first, input int gap);
    if (w_first) begin w_handshake(data, strb); repeat (gap) tick(); aw_handshake(addr); end
    else         begin aw_handshake(addr); repeat (gap) tick(); w_handshake(data, strb); end
    checks++;
    if (reg_req !== 1'b0) begin failures++; $display("FAIL write_grant_cycle reg_req=%b required=0", reg_req); end
    tick();
    checks++;
    if (reg_req !== 1'b1) begin failures++; $display("FAIL write_latency reg_req=%b required=1", reg_req); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb, axi.arready, axi.awready, axi.wready,
         axi.bvalid, axi.rvalid, axi.b.resp, axi.r.resp, axi.r.data} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0}) begin
      failures++;
      $display("FAIL reset_values req=%b addr=%h arready=%b awready=%b wready=%b bvalid=%b rvalid=%b rdata=%h required idle values",
               reg_req, reg_addr, axi.arready, axi.awready, axi.wready, axi.bvalid, axi.rvalid, axi.r.data);
    end
  endtask

  task automatic test_single_read();
    do_read(32'h0000_0104, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 2);
  endtask

  task automatic test_w_before_aw();
    issue_write(32'h0000_0013, 32'h1234_5678, 4'b0101, 1'b1, 5);
    serve(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0101, 1'b1, 2, 32'h0, 1'b0, 1);
  endtask

  task automatic test_arbitration();
    logic [31:0] ra, wa, wd;
    bit read_wins;
    apply_reset();
    for (int it = 0; it < 4; it++) begin
      ra = $urandom; wa = $urandom; wd = $urandom;
      axi.awvalid = 1; axi.aw.addr = wa; axi.wvalid = 1; axi.w.data = wd; axi.w.strb = 4'hF;
      tick();
      axi.awvalid = 0; axi.wvalid = 0;
      axi.arvalid = 1; axi.ar.addr = ra;
      read_wins = m_last_write;
      @(negedge aclk);
      checks++;
      if (axi.arready !== read_wins) begin
        failures++; $display("FAIL arb_tie it=%0d arready=%b required=%b", it, axi.arready, read_wins);
      end
      if (read_wins) begin
        serve(1'b0, word(ra), 32'h0, 4'h0, 1'b1, 1, ~ra, 1'b0, 0);
        serve(1'b1, word(wa), wd, 4'hF, 1'b1, 2, 32'h0, 1'b0, 0);
      end else begin
        serve(1'b1, word(wa), wd, 4'hF, 1'b1, 2, 32'h0, 1'b0, 0);
        serve(1'b0, word(ra), 32'h0, 4'h0, 1'b1, 1, ~ra, 1'b0, 0);
      end
    end
  endtask

  task automatic test_timeout();
    do_read(32'h0000_0040, 1'b0, 0, 32'h0, 1'b0, 3);
  endtask

  task automatic test_write_error();
    issue_write(32'h0000_0A08, 32'hCAFE_F00D, 4'b1111, 1'b0, 0);
    axi.arvalid = 1; axi.ar.addr = 32'h0000_0A0C;
    serve(1'b1, 32'h0000_0A08, 32'hCAFE_F00D, 4'b1111, 1'b1, 1, 32'h0, 1'b1, 10);
    serve(1'b0, 32'h0000_0A0C, 32'h0, 4'h0, 1'b1, 2, 32'h5A5A_A5A5, 1'b0, 0);
  endtask

  task automatic test_reset_mid_op();
    w_handshake(32'h1111_2222, 4'h3);
    ar_handshake(32'h0000_0200);
    checks++;
    if (reg_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req reg_req=%b required=1", reg_req); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({reg_req, axi.awready, axi.wready, axi.bvalid, axi.rvalid} !== 5'b01100) begin
      failures++;
      $display("FAIL async_reset req=%b awready=%b wready=%b bvalid=%b rvalid=%b required 0 1 1 0 0",
               reg_req, axi.awready, axi.wready, axi.bvalid, axi.rvalid);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    m_last_write = 1'b1;
    aw_handshake(32'h0000_0300);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (reg_req !== 1'b0) begin failures++; $display("FAIL w_discarded reg_req=%b required=0", reg_req); end
    end
    do_read(32'h0000_0204, 1'b1, 2, 32'h0BAD_CAFE, 1'b0, 1);
    w_handshake(32'h3333_4444, 4'hC);
    tick();
    checks++;
    if (reg_req !== 1'b1) begin failures++; $display("FAIL post_reset_write reg_req=%b required=1", reg_req); end
    serve(1'b1, 32'h0000_0300, 32'h3333_4444, 4'hC, 1'b1, 1, 32'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit ack_en, err;
    for (int it = 0; it < 16; it++) begin
      a = $urandom; d = $urandom; s = 4'($urandom_range(0, 15));
      ack_en = ($urandom_range(0, 7) != 0);
      err = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, ack_en, $urandom_range(1, 5), d, err, $urandom_range(0, 3));
      end else begin
        issue_write(a, d, s, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
        serve(1'b1, word(a), d, s, ack_en, $urandom_range(1, 5), 32'h0, err, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_w_before_aw();
    test_arbitration();
    test_timeout();
    test_write_error();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
